// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Raster timing generator for the VGA output path. A pixel-clock divider
// drives a horizontal counter, and the horizontal counter drives a vertical
// counter. Sync, video-enable and the coordinates are decoded
// combinationally from the registered counters, so they all change on the
// same clk edge as the counters.
//
// Ports
//   clk          system clock
//   Mreset       synchronous active-high reset (has priority over Mstart)
//   Mstart       level run enable; while low the scan is frozen
//   h_sync       horizontal sync, asserted level = SYNC_POL
//   v_sync       vertical sync, asserted level = SYNC_POL
//   PX, PY       current horizontal / vertical count
//   vidwe        high inside the visible window (after run has been set)
//   pix_tick     one-clk pulse on each pixel advance
//   line_start   pix_tick at hcnt == 0
//   frame_start  line_start at vcnt == 0
//   frame_cnt    completed frames, modulo 2^FW
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int PIX_DIV  = 2,
  parameter int XW       = 10,
  parameter int YW       = 10,
  parameter int FW       = 8
) (
  input  logic          clk,
  input  logic          Mreset,
  input  logic          Mstart,
  output logic          h_sync,
  output logic          v_sync,
  output logic [XW-1:0] PX,
  output logic [YW-1:0] PY,
  output logic          vidwe,
  output logic          pix_tick,
  output logic          line_start,
  output logic          frame_start,
  output logic [FW-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Divider width; PIX_DIV == 1 still gets a 1-bit register that stays 0.
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_END = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYN_BEG = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYN_END = XW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYN_BEG = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYN_END = YW'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_LVL = (SYNC_POL != 0);

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [DW-1:0] div;
  logic [XW-1:0] hcnt;
  logic [YW-1:0] vcnt;
  logic          run;

  logic h_last, v_last;
  logic h_sync_act, v_sync_act;

  assign h_last = (hcnt == H_LAST);
  assign v_last = (vcnt == V_LAST);

  // Tick depends on the live Mstart level so that a pause takes effect in
  // the very cycle Mstart drops; no pixel is skipped or repeated on resume.
  assign pix_tick = Mstart && (div == DIV_LAST);

  // run: sticky once Mstart is seen, cleared only by reset.
  always_ff @(posedge clk) begin
    if (Mreset) begin
      run <= 1'b0;
    end else if (Mstart) begin
      run <= 1'b1;
    end
  end

  // Pixel-clock divider: free-running while Mstart is high, frozen otherwise.
  always_ff @(posedge clk) begin
    if (Mreset) begin
      div <= '0;
    end else if (Mstart) begin
      if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  // Horizontal counter: advances on each pixel tick, wraps at end of line.
  always_ff @(posedge clk) begin
    if (Mreset) begin
      hcnt <= '0;
    end else if (pix_tick) begin
      if (h_last) begin
        hcnt <= '0;
      end else begin
        hcnt <= hcnt + 1'b1;
      end
    end
  end

  // Vertical counter: advances on the last pixel of each line.
  always_ff @(posedge clk) begin
    if (Mreset) begin
      vcnt <= '0;
    end else if (pix_tick && h_last) begin
      if (v_last) begin
        vcnt <= '0;
      end else begin
        vcnt <= vcnt + 1'b1;
      end
    end
  end

  // Frame counter: bumps on the last pixel of the last line; natural
  // wrap of the FW-bit register gives the modulo-2^FW behaviour.
  always_ff @(posedge clk) begin
    if (Mreset) begin
      frame_cnt <= '0;
    end else if (pix_tick && h_last && v_last) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Decodes (combinational from registered state)
  // ---------------------------------------------------------------------
  assign PX = hcnt;
  assign PY = vcnt;

  assign vidwe = run && (hcnt < H_ACT_END) && (vcnt < V_ACT_END);

  assign h_sync_act = (hcnt >= H_SYN_BEG) && (hcnt < H_SYN_END);
  assign v_sync_act = (vcnt >= V_SYN_BEG) && (vcnt < V_SYN_END);

  assign h_sync = h_sync_act ? SYNC_LVL : ~SYNC_LVL;
  assign v_sync = v_sync_act ? SYNC_LVL : ~SYNC_LVL;

  assign line_start  = pix_tick && (hcnt == '0);
  assign frame_start = line_start && (vcnt == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Instance a uses the small timing
// (H 8/2/3/3, V 4/1/2/1, PIX_DIV=2, active-low sync, FW=2); the expected
// state of every pixel tick is queued by the stimulus and checked by a
// separate monitor. Instance b uses PIX_DIV=1 with active-high sync.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance a ----------------
  logic       rst_a, start_a;
  logic       hs_a, vs_a, vid_a, tick_a, ls_a, fs_a;
  logic [9:0] px_a, py_a;
  logic [1:0] fc_a;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(0), .PIX_DIV(2), .XW(10), .YW(10), .FW(2)
  ) dut_a (
    .clk(clk), .Mreset(rst_a), .Mstart(start_a),
    .h_sync(hs_a), .v_sync(vs_a), .PX(px_a), .PY(py_a),
    .vidwe(vid_a), .pix_tick(tick_a), .line_start(ls_a),
    .frame_start(fs_a), .frame_cnt(fc_a)
  );

  // ---------------- instance b ----------------
  logic       rst_b, start_b;
  logic       hs_b, vs_b, vid_b, tick_b, ls_b, fs_b;
  logic [9:0] px_b, py_b;
  logic [1:0] fc_b;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1), .PIX_DIV(1), .XW(10), .YW(10), .FW(2)
  ) dut_b (
    .clk(clk), .Mreset(rst_b), .Mstart(start_b),
    .h_sync(hs_b), .v_sync(vs_b), .PX(px_b), .PY(py_b),
    .vidwe(vid_b), .pix_tick(tick_b), .line_start(ls_b),
    .frame_start(fs_b), .frame_cnt(fc_b)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int px, py, hs, vs, vid, ls, fs, fc;
  } exp_t;

  exp_t sbq[$];
  int passes = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected raster position of the next pixel tick on instance a.
  int ex = 0, ey = 0, efc = 0;

  task automatic push_pixel();
    exp_t e;
    e.px  = ex;
    e.py  = ey;
    e.hs  = (ex >= 10 && ex <= 12) ? 0 : 1;
    e.vs  = (ey >= 5 && ey <= 6) ? 0 : 1;
    e.vid = (ex < 8 && ey < 4) ? 1 : 0;
    e.ls  = (ex == 0) ? 1 : 0;
    e.fs  = (ex == 0 && ey == 0) ? 1 : 0;
    e.fc  = efc;
    sbq.push_back(e);
    ex++;
    if (ex == 16) begin
      ex = 0;
      ey++;
      if (ey == 8) begin
        ey  = 0;
        efc = (efc + 1) % 4;
      end
    end
  endtask

  // Queue n pixels and run exactly 2n clocks (starts and ends at div=0).
  task automatic run_pixels(input int n);
    repeat (n) push_pixel();
    repeat (2 * n) @(posedge clk);
    #1;
  endtask

  // Monitor: every pixel tick of instance a consumes one expected record.
  always @(negedge clk) begin
    if (tick_a) begin
      if (sbq.size() == 0) begin
        chk("unexpected_tick", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("tick_px", int'(px_a), e.px);
        chk("tick_py", int'(py_a), e.py);
        chk("tick_hsync", int'(hs_a), e.hs);
        chk("tick_vsync", int'(vs_a), e.vs);
        chk("tick_vidwe", int'(vid_a), e.vid);
        chk("tick_line_start", int'(ls_a), e.ls);
        chk("tick_frame_start", int'(fs_a), e.fs);
        chk("tick_frame_cnt", int'(fc_a), e.fc);
      end
    end
  end

  // Period and window measurements on instance a.
  bit meas_en = 0, cnt_en = 0;
  int cyc = 0, last_ls = -1, last_fs = -1;
  int vs_low = 0, hs_low = 0, vid_hi = 0;

  always @(negedge clk) begin
    cyc++;
    if (meas_en) begin
      if (ls_a) begin
        if (last_ls >= 0) chk("line_period", cyc - last_ls, 32);
        last_ls = cyc;
      end
      if (fs_a) begin
        if (last_fs >= 0) chk("frame_period", cyc - last_fs, 256);
        last_fs = cyc;
      end
    end
    if (cnt_en) begin
      if (!vs_a) vs_low++;
      if (!hs_a) hs_low++;
      if (vid_a) vid_hi++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_a = 1'b1; start_a = 1'b0;
    rst_b = 1'b1; start_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state, both instances.
    chk("rst_px", int'(px_a), 0);
    chk("rst_py", int'(py_a), 0);
    chk("rst_hsync", int'(hs_a), 1);
    chk("rst_vsync", int'(vs_a), 1);
    chk("rst_vidwe", int'(vid_a), 0);
    chk("rst_tick", int'(tick_a), 0);
    chk("rst_frame_cnt", int'(fc_a), 0);
    chk("rst_b_hsync", int'(hs_b), 0);
    chk("rst_b_vsync", int'(vs_b), 0);

    rst_a = 1'b0;
    @(posedge clk); #1;
    chk("idle_vidwe", int'(vid_a), 0);
    chk("idle_tick", int'(tick_a), 0);

    // Start: no tick on the first enabled clk (div=0), vidwe follows one clk later.
    meas_en = 1;
    start_a = 1'b1;
    #1;
    chk("first_clk_tick", int'(tick_a), 0);
    chk("first_clk_vidwe", int'(vid_a), 0);

    // Frame 1.
    run_pixels(128);
    chk("fc_after_frame1", int'(fc_a), 1);

    // Frame 2, with window counts.
    vs_low = 0; hs_low = 0; vid_hi = 0;
    cnt_en = 1;
    run_pixels(128);
    cnt_en = 0;
    chk("vsync_low_clks", vs_low, 64);   // 2 lines x 16 px x 2 clk
    chk("hsync_low_clks", hs_low, 48);   // 3 px x 2 clk x 8 lines
    chk("vidwe_high_clks", vid_hi, 64);  // 8 px x 2 clk x 4 lines
    chk("fc_after_frame2", int'(fc_a), 2);

    // Frames 3..5: frame_cnt wraps 3 -> 0 -> 1.
    run_pixels(256);
    chk("fc_wrap", int'(fc_a), 0);
    run_pixels(128);
    chk("fc_after_frame5", int'(fc_a), 1);
    meas_en = 0;

    // Pause at hcnt=5, div=1.
    run_pixels(5);
    push_pixel();
    @(posedge clk); #1;
    start_a = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      chk("pause_px", int'(px_a), 5);
      chk("pause_tick", int'(tick_a), 0);
      chk("pause_line_start", int'(ls_a), 0);
      chk("pause_frame_start", int'(fs_a), 0);
      @(posedge clk); #1;
    end
    start_a = 1'b1;
    @(posedge clk); #1;
    chk("resume_px", int'(px_a), 6);

    // Move to hcnt=9, vcnt=2 and reset mid-frame with Mstart still high.
    run_pixels(35);
    chk("pre_rst_px", int'(px_a), 9);
    chk("pre_rst_py", int'(py_a), 2);
    rst_a = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_px", int'(px_a), 0);
    chk("mid_rst_py", int'(py_a), 0);
    chk("mid_rst_hsync", int'(hs_a), 1);
    chk("mid_rst_vsync", int'(vs_a), 1);
    chk("mid_rst_vidwe", int'(vid_a), 0);
    chk("mid_rst_tick", int'(tick_a), 0);
    chk("mid_rst_line_start", int'(ls_a), 0);
    chk("mid_rst_frame_start", int'(fs_a), 0);
    chk("mid_rst_frame_cnt", int'(fc_a), 0);

    // run must be re-armed by Mstart after reset.
    rst_a = 1'b0; start_a = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_vidwe", int'(vid_a), 0);
    ex = 0; ey = 0; efc = 0;
    start_a = 1'b1;
    run_pixels(3);
    start_a = 1'b0;
    chk("scoreboard_drained", sbq.size(), 0);

    // Instance b: PIX_DIV=1, active-high sync, 16-clk line.
    rst_b = 1'b0;
    @(posedge clk); #1;
    start_b = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      chk("b_tick", int'(tick_b), 1);
      chk("b_px", int'(px_b), k % 16);
      chk("b_hsync", int'(hs_b), ((k % 16) >= 10 && (k % 16) <= 12) ? 1 : 0);
      chk("b_vsync", int'(vs_b), 0);
      chk("b_line_start", int'(ls_b), (k % 16 == 0) ? 1 : 0);
      chk("b_vidwe", int'(vid_b), (k > 0 && (k % 16) < 8) ? 1 : 0);
      @(posedge clk); #1;
    end
    start_b = 1'b0;
    #1;
    chk("b_pause_tick", int'(tick_b), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
